fm_demodulate: RTL



---
 rtl/fm_demodulate.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fm_demodulate.sv
// fm_demodulate: zero-crossing FM discriminator with hysteresis, period
// averaging over 2^AVG_LOG2 carrier cycles and saturated deviation output.
module fm_demodulate #(
  parameter int INPUT_WIDTH  = 12,
  parameter int CNT_WIDTH    = 16,
  parameter int AVG_LOG2     = 2,
  parameter int HYST         = 64,
  parameter int GAIN_SHIFT   = 0,
  parameter int OUTPUT_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic [INPUT_WIDTH-1:0]        FM_wave,
  input  logic [CNT_WIDTH+AVG_LOG2-1:0] center_period,
  output logic [OUTPUT_WIDTH-1:0]       wave_out,
  output logic                          wave_valid,
  output logic [CNT_WIDTH+AVG_LOG2-1:0] period_out,
  output logic                          lock
);

  localparam int PW = CNT_WIDTH + AVG_LOG2;
  localparam int DW = PW + 1;
  localparam int SW = DW + GAIN_SHIFT;
  localparam int BW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'((1 << AVG_LOG2) - 1);

  localparam logic signed [INPUT_WIDTH-1:0] HYST_P =
    INPUT_WIDTH'(HYST);
  localparam logic signed [INPUT_WIDTH-1:0] HYST_N = -HYST_P;

  localparam logic signed [SW-1:0] OMAX =
    SW'((1 << (OUTPUT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] OMIN = -OMAX - SW'(1);

  typedef enum logic [1:0] {
    IDLE,
    NEG,
    POS
  } state_e;

  state_e state_q, state_d;

  logic signed [INPUT_WIDTH-1:0] s_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]        sum_q, sum_d;
  logic [BW-1:0]        blk_q, blk_d;
  logic                 first_q, first_d;
  logic [PW-1:0]        final_q, final_d;
  logic                 done_q, done_d;

  logic [OUTPUT_WIDTH-1:0] wave_q, wave_d;
  logic                    valid_q, valid_d;
  logic [PW-1:0]           period_q, period_d;
  logic                    lock_q, lock_d;

  logic hi, lo, rise, timeout;
  logic [PW-1:0] sum_acc;
  logic signed [DW-1:0] dev;
  logic signed [SW-1:0] dev_sh;
  logic [OUTPUT_WIDTH-1:0] wave_sat;

  assign hi = (s_q >= HYST_P);
  assign lo = (s_q <= HYST_N);

  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hi) state_d = POS;
        else if (lo) state_d = NEG;
      end
      NEG: begin
        if (hi) begin
          state_d = POS;
          rise    = 1'b1;
        end
      end
      POS: begin
        if (lo) state_d = NEG;
      end
      default: state_d = IDLE;
    endcase
  end

  assign timeout = &cnt_q;
  assign sum_acc = sum_q + PW'(cnt_q);

  always_comb begin
    if (rise) cnt_d = CNT_WIDTH'(1);
    else if (timeout) cnt_d = cnt_q;
    else cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Timeout wipes the partial block; a coincident rise restarts acquisition.
  always_comb begin
    sum_d   = sum_q;
    blk_d   = blk_q;
    first_d = first_q;
    final_d = final_q;
    done_d  = 1'b0;
    if (timeout) begin
      sum_d   = '0;
      blk_d   = '0;
      first_d = rise;
    end else if (rise) begin
      if (!first_q) begin
        first_d = 1'b1;
      end else if (blk_q == BLK_LAST) begin
        final_d = sum_acc;
        sum_d   = '0;
        blk_d   = '0;
        done_d  = 1'b1;
      end else begin
        sum_d = sum_acc;
        blk_d = blk_q + BW'(1);
      end
    end
  end

  assign dev = $signed({1'b0, center_period}) - $signed({1'b0, final_q});
  assign dev_sh = SW'(dev) <<< GAIN_SHIFT;

  always_comb begin
    if (dev_sh > OMAX) wave_sat = OMAX[OUTPUT_WIDTH-1:0];
    else if (dev_sh < OMIN) wave_sat = OMIN[OUTPUT_WIDTH-1:0];
    else wave_sat = dev_sh[OUTPUT_WIDTH-1:0];
  end

  always_comb begin
    wave_d   = wave_q;
    valid_d  = 1'b0;
    period_d = period_q;
    lock_d   = lock_q;
    if (timeout) begin
      lock_d = 1'b0;
      wave_d = '0;
    end else if (done_q) begin
      wave_d   = wave_sat;
      valid_d  = 1'b1;
      period_d = final_q;
      lock_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      s_q      <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      blk_q    <= '0;
      first_q  <= 1'b0;
      final_q  <= '0;
      done_q   <= 1'b0;
      wave_q   <= '0;
      valid_q  <= 1'b0;
      period_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= FM_wave;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      blk_q    <= blk_d;
      first_q  <= first_d;
      final_q  <= final_d;
      done_q   <= done_d;
      wave_q   <= wave_d;
      valid_q  <= valid_d;
      period_q <= period_d;
      lock_q   <= lock_d;
    end
  end

  assign wave_out   = wave_q;
  assign wave_valid = valid_q;
  assign period_out = period_q;
  assign lock       = lock_q;

endmodule
